// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction-fetch and data requesters,
// with a bus timeout. Define MEM_ARB_ROUND_ROBIN_EN for alternating grants under contention.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_rd_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_rd_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUS_I,
        BUS_D,
        RESP
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_mem_req, w_mem_req_nxt;
    logic                r_mem_rd_wr, w_mem_rd_wr_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0]   r_i_rdata, w_i_rdata_nxt;
    logic [DATA_W-1:0]   r_d_rdata, w_d_rdata_nxt;
    logic                r_i_ack, w_i_ack_nxt;
    logic                r_d_ack, w_d_ack_nxt;
    logic                r_bus_err, w_bus_err_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_timeout;
    logic                w_grant_d;

    // Saturating wait counter; timeout fires when the next count would reach TIMEOUT
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == CNT_W'(TIMEOUT));

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_grant_d, w_last_grant_d_nxt;

    // Under contention the port not served last wins
    assign w_grant_d = d_req && (!i_req || !r_last_grant_d);

    always_comb begin
        w_last_grant_d_nxt = r_last_grant_d;
        if (r_state == IDLE && (i_req || d_req)) begin
            w_last_grant_d_nxt = w_grant_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant_d <= 1'b0;
        end else begin
            r_last_grant_d <= w_last_grant_d_nxt;
        end
    end
`else
    assign w_grant_d = d_req;
`endif

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_rd_wr_nxt = r_mem_rd_wr;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_i_rdata_nxt   = r_i_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_i_ack_nxt     = 1'b0;
        w_d_ack_nxt     = 1'b0;
        w_bus_err_nxt   = 1'b0;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_grant_d) begin
                    w_state_nxt     = BUS_D;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_rd_wr_nxt = d_rd_wr;
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_wdata;
                end else if (i_req) begin
                    w_state_nxt     = BUS_I;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_rd_wr_nxt = 1'b1;
                    w_mem_addr_nxt  = i_addr;
                end
            end
            BUS_I, BUS_D: begin
                if (mem_ack || w_timeout) begin
                    w_state_nxt   = RESP;
                    w_mem_req_nxt = 1'b0;
                    w_bus_err_nxt = !mem_ack;
                    if (r_state == BUS_I) begin
                        w_i_ack_nxt   = 1'b1;
                        w_i_rdata_nxt = mem_ack ? mem_rdata : '0;
                    end else begin
                        w_d_ack_nxt = 1'b1;
                        if (r_mem_rd_wr) begin
                            w_d_rdata_nxt = mem_ack ? mem_rdata : '0;
                        end
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            RESP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_rd_wr <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_bus_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_rd_wr <= w_mem_rd_wr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_i_rdata   <= w_i_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_i_ack     <= w_i_ack_nxt;
            r_d_ack     <= w_d_ack_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_rd_wr = r_mem_rd_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (TIMEOUT = 15).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_rd_wr, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ack, d_ack, mem_req, mem_rd_wr, bus_err;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_rd_wr(d_rd_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic        rd_wr;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          delay;     // cycles from mem_req rise to mem_ack; 255 = never
        logic        exp_d;     // expected grantee is the data port
        logic [31:0] exp_rdata; // grantee's read-data output after completion
        logic        exp_err;
        logic        hold;      // keep requests asserted through the ack cycle
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
        chk({tag, "_mem_rd_wr"}, 32'(mem_rd_wr), 32'd1);
        chk({tag, "_mem_addr"},  mem_addr,       32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        chk({tag, "_i_ack"},     32'(i_ack),     32'd0);
        chk({tag, "_d_ack"},     32'(d_ack),     32'd0);
        chk({tag, "_i_rdata"},   i_rdata,        32'd0);
        chk({tag, "_d_rdata"},   d_rdata,        32'd0);
        chk({tag, "_bus_err"},   32'(bus_err),   32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string t;
        int    n;
        t = $sformatf("v%0d", idx);
        i_req = v.ireq; d_req = v.dreq; d_rd_wr = v.rd_wr;
        i_addr = v.iaddr; d_addr = v.daddr; d_wdata = v.wdata;
        tick();
        chk({t, "_mem_req_rise"}, 32'(mem_req), 32'd1);
        chk({t, "_mem_addr"}, mem_addr, v.exp_d ? v.daddr : v.iaddr);
        chk({t, "_mem_rd_wr"}, 32'(mem_rd_wr), v.exp_d ? 32'(v.rd_wr) : 32'd1);
        if (v.exp_d && !v.rd_wr) chk({t, "_mem_wdata"}, mem_wdata, v.wdata);
        if (v.delay == 255) begin
            n = 0;
            while (!(i_ack || d_ack) && n < 40) begin
                tick();
                n++;
            end
            chk({t, "_timeout_cycles"}, 32'(n), 32'd15);
        end else begin
            repeat (v.delay) tick();
            chk({t, "_mem_req_held"}, 32'(mem_req), 32'd1);
            mem_ack = 1'b1; mem_rdata = v.mrdata;
            tick();
            mem_ack = 1'b0; mem_rdata = 32'h0BAD_0BAD;
        end
        chk({t, "_mem_req_fall"}, 32'(mem_req), 32'd0);
        chk({t, "_i_ack"}, 32'(i_ack), v.exp_d ? 32'd0 : 32'd1);
        chk({t, "_d_ack"}, 32'(d_ack), v.exp_d ? 32'd1 : 32'd0);
        chk({t, "_rdata"}, v.exp_d ? d_rdata : i_rdata, v.exp_rdata);
        chk({t, "_bus_err"}, 32'(bus_err), 32'(v.exp_err));
        if (!v.hold) begin
            i_req = 1'b0; d_req = 1'b0;
        end
        tick();
        chk({t, "_ack_done"}, 32'({i_ack, d_ack, bus_err}), 32'd0);
    endtask

    initial begin
        logic cont_d1, cont_d3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        cont_d1 = 1'b0; cont_d3 = 1'b0;
`else
        cont_d1 = 1'b1; cont_d3 = 1'b1;
`endif
        //         ireq  dreq  rd_wr iaddr         daddr         wdata         mrdata        dly  exp_d    exp_rdata     err   hold
        vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0,        32'h0,        32'h2409_0005, 2,   1'b0,    32'h2409_0005, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678, 1,   1'b1,    32'h0,        1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0,   1'b1,    32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_0044, 32'h0,        32'h0,        32'h1111_2222, 3,   1'b0,    32'h1111_2222, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0200, 32'h0,        32'hA000_0001, 1,   1'b1,    32'hA000_0001, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0200, 32'h0,        32'hA000_0002, 0,   cont_d1, 32'hA000_0002, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0200, 32'h0,        32'hA000_0003, 2,   1'b1,    32'hA000_0003, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0200, 32'h0,        32'hA000_0004, 1,   cont_d3, 32'hA000_0004, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_0300, 32'h0,        32'h0,        255, 1'b1,    32'h0,        1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 32'h0000_0048, 32'h0,        32'h0,        32'h3333_4444, 1,   1'b0,    32'h3333_4444, 1'b0, 1'b0};

        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_rd_wr = 1'b1; mem_ack = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        chk_reset_outputs("reset");
        tick();
        chk_reset_outputs("idle");

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Stray memory ack while idle must be ignored
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack = 1'b0;
        chk("stray_acks", 32'({i_ack, d_ack, bus_err, mem_req}), 32'd0);
        tick();
        chk("stray_acks2", 32'({i_ack, d_ack, bus_err, mem_req}), 32'd0);
        chk("stray_i_rdata", i_rdata, 32'h3333_4444);

        // Requester drops req mid-transfer; ack still pulses
        i_req = 1'b1; i_addr = 32'h0000_0600;
        tick();
        chk("drop_mem_req", 32'(mem_req), 32'd1);
        i_req = 1'b0; i_addr = 32'h0000_0999;
        tick();
        chk("drop_addr_stable", mem_addr, 32'h0000_0600);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        tick();
        mem_ack = 1'b0;
        chk("drop_i_ack", 32'(i_ack), 32'd1);
        chk("drop_i_rdata", i_rdata, 32'hCAFE_0001);
        tick();
        chk("drop_idle", 32'({i_ack, d_ack, mem_req}), 32'd0);

        // Reset while in BUS_I, then a late mem_ack
        i_req = 1'b1; i_addr = 32'h0000_0500;
        tick();
        chk("rst_mem_req", 32'(mem_req), 32'd1);
        tick();
        reset = 1'b1; i_req = 1'b0;
        tick();
        reset = 1'b0;
        chk_reset_outputs("rst_mid");
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_ack = 1'b0;
        chk_reset_outputs("rst_late_ack");
        tick();
        chk("rst_no_ack", 32'({i_ack, d_ack, mem_req}), 32'd0);

        // Confirms the FSM sits in IDLE: a fresh fetch starts with normal latency
        i_req = 1'b1; i_addr = 32'h0000_0700;
        tick();
        chk("post_rst_req", 32'(mem_req), 32'd1);
        chk("post_rst_addr", mem_addr, 32'h0000_0700);
        mem_ack = 1'b1; mem_rdata = 32'h0101_0202;
        tick();
        mem_ack = 1'b0; i_req = 1'b0;
        chk("post_rst_ack", 32'(i_ack), 32'd1);
        chk("post_rst_rdata", i_rdata, 32'h0101_0202);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
